// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Round-robin arbiter between two masters sharing one single-ported word
//   memory. Each access is serialised as IDLE -> ACCESS -> RESP: the granted
//   port's address/data/write are latched onto the memory bus, held for
//   MEM_LAT cycles, the read data is captured, and a one-cycle ack is returned
//   to the owning port.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req0/we0/addr0/wdata0 port 0 request, write enable, word address, write data
//   ack0/rdata0           port 0 completion pulse, captured read data
//   req1 .. rdata1        same for port 1
//   MAR/MBR_W/write       memory address, write data, write strobe
//   MBR_R                 memory read data
//   busy                  high while an access is in flight (ACCESS, RESP)
//   owner                 index of the port last granted
module mem_port_arbiter #(
  parameter int unsigned BITS_DATA = 32,
  parameter int unsigned BITS_ADDR = 16,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [BITS_ADDR-1:0] addr0,
  input  logic [BITS_DATA-1:0] wdata0,
  output logic                 ack0,
  output logic [BITS_DATA-1:0] rdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [BITS_ADDR-1:0] addr1,
  input  logic [BITS_DATA-1:0] wdata1,
  output logic                 ack1,
  output logic [BITS_DATA-1:0] rdata1,
  output logic [BITS_ADDR-1:0] MAR,
  output logic [BITS_DATA-1:0] MBR_W,
  output logic                 write,
  input  logic [BITS_DATA-1:0] MBR_R,
  output logic                 busy,
  output logic                 owner
);

  if (MEM_LAT == 0 || MEM_LAT > 15) begin : g_lat_check
    $error("mem_port_arbiter: MEM_LAT must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       last;
  logic       sel;

  // On a tie the port that was not served last wins; otherwise the lone
  // requester wins (sel defaults to port 0 when req1 is low).
  always_comb begin
    sel = req1;
    if (req0 && req1) begin
      sel = ~last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req0 || req1) state_next = ACCESS;
      ACCESS:  if (cnt == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Bus, ack and read-data registers. The latched write strobe doubles as
  // the read/write flag of the access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MAR    <= '0;
      MBR_W  <= '0;
      write  <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      owner  <= 1'b0;
      last   <= 1'b1;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner <= sel;
            cnt   <= CNT_INIT;
            if (sel) begin
              MAR   <= addr1;
              write <= we1;
              if (we1) MBR_W <= wdata1;
            end else begin
              MAR   <= addr0;
              write <= we0;
              if (we0) MBR_W <= wdata0;
            end
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            write <= 1'b0;
            last  <= owner;
            if (owner) begin
              ack1 <= 1'b1;
              if (!write) rdata1 <= MBR_R;
            end else begin
              ack0 <= 1'b1;
              if (!write) rdata0 <= MBR_R;
            end
          end
        end
        RESP: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
